uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver, next generation of the single-config RX. Configurable data
//  width, stop bits and oversampling. Majority-vote mid-bit sampling, false-start rejection,
//  valid/ready output handshake with overrun detection. Sits between pad rx and a consumer.
// PARAMETERS
//  FCLK        50000000  system clock frequency, Hz
//  FBAUD       115200    baud rate, Hz
//  OVERSAMPLE  16        sample ticks per bit; even, >=4
//  DATA_W      8         data bits per frame, 5..9
//  STOP_BITS   1         stop bits checked, 1 or 2
//  SYNC_STAGES 2         rx synchroniser depth, >=2
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       reset, synchronous, active-low
//  rx           in   1       serial line, async, idle high
//  par_mode     in   2       00 none, 01 even, 10 odd, 11 = none; see CONFIGURATION
//  rx_data      out  DATA_W  received word, LSB first on line
//  rx_valid     out  1       rx_data/frame_err/parity_err valid
//  rx_ready     in   1       consumer accepts word
//  rx_idle      out  1       FSM in IDLE
//  frame_err    out  1       a stop bit sampled 0; qualified by rx_valid
//  parity_err   out  1       parity mismatch; qualified by rx_valid
//  overrun_err  out  1       1-clk pulse: frame completed while rx_valid && !rx_ready
// BEHAVIOUR
//  - One clock; reset synchronous, active-low. Reset: rx_data=0, rx_valid=0, frame_err=0,
//    parity_err=0, overrun_err=0, rx_idle=1, synchroniser flops=1, state IDLE.
//    Reset mid-frame aborts the frame; no rx_valid is produced.
//  - TICK_DIV = FCLK/(FBAUD*OVERSAMPLE), must be >=1 ($error at elaboration otherwise,
//    also for illegal DATA_W/STOP_BITS/OVERSAMPLE). Tick prescaler reloads on start detect.
//  - Widths: tick cnt $clog2(TICK_DIV+1), sample cnt $clog2(OVERSAMPLE), bit cnt $clog2(DATA_W+1).
//  - Bit value = majority of samples OVERSAMPLE/2-1, /2, /2+1 of that bit.
//  - FSM: IDLE -> START on synchronised 1->0 edge (line must have been seen high first).
//    START: majority 1 -> IDLE (false start, no output); 0 -> DATA at end of bit.
//    DATA: DATA_W bits, LSB first -> PAR if parity enabled, else STOP.
//    PAR: one bit, checked against parity of DATA bits -> STOP.
//    STOP: STOP_BITS bits; any sampled 0 sets frame_err. After middle sample of last stop
//    bit -> IDLE (half-bit early, allows back-to-back frames).
//  - Output: word loaded at last stop mid-sample; rx_valid rises next clk, holds until
//    rx_valid && rx_ready clk, then 0. rx_data and error flags stable while rx_valid.
//  - Frame errors still deliver the word (frame_err=1). Break (line low): word 0 with
//    frame_err; FSM re-arms only after rx seen high.
//  - Overrun: new word completes while rx_valid && !rx_ready -> new word dropped, old kept,
//    overrun_err pulses 1 clk. Completion in same clk as handshake: new word loaded, no overrun.
// CONFIGURATION
//  - UART_RX_CFG_PARITY_EN defined: par_mode sampled at start detect, held for the frame;
//    01/10 add PAR state and drive parity_err.
//  - Not defined: par_mode ignored, no PAR state, parity_err tied 0.
// TESTING  (FCLK=1600000, FBAUD=10000, OVERSAMPLE=16 -> TICK_DIV=10, 160 clk/bit)
//  1. 0xA5, 8N1, rx_ready=1 -> one rx_valid clk, rx_data=0xA5, all errors 0, rx_idle=1 after.
//  2. 60-clk low glitch on idle line -> no rx_valid, back to IDLE, next 0x3C frame received.
//  3. 0x3C with stop bit 0 -> rx_data=0x3C, frame_err=1; 1 bit idle, 0x81 -> clean.
//  4. 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_data=0x11 held, overrun_err 1 clk at 2nd;
//     rx_ready=1 -> rx_valid falls next clk.
//  5. Macro on, par_mode=01, 0x07 parity bit 0 -> parity_err=1; bit 1 -> 0; macro off, same
//     stimulus without parity bit -> parity_err=0.
//  6. rst_n low 1 clk during DATA bit 4 -> rx_valid=0, rx_idle=1; following 0x5A clean.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver, majority-vote sampling, valid/ready out.
// Define UART_RX_CFG_PARITY_EN to add the optional parity bit (par_mode).
module uart_rx_cfg #(
  parameter int FCLK        = 50000000,
  parameter int FBAUD       = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_W      = 8,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx,
  input  logic [1:0]        par_mode,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              rx_idle,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun_err
);

  localparam int TICK_DIV = FCLK / (FBAUD * OVERSAMPLE);
  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [TW-1:0] T_END   = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SMP_LO  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SMP_MID = SW'(OVERSAMPLE / 2);
  localparam logic [SW-1:0] SMP_HI  = SW'(OVERSAMPLE / 2 + 1);
  localparam logic [SW-1:0] SMP_END = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_DLAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] B_SLAST = BW'(STOP_BITS - 1);

  if (TICK_DIV < 1) begin : g_bad_div
    $error("uart_rx_cfg: FCLK/(FBAUD*OVERSAMPLE) must be >= 1");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_dw
    $error("uart_rx_cfg: DATA_W must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_sb
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (OVERSAMPLE < 4 || OVERSAMPLE % 2 != 0) begin : g_bad_os
    $error("uart_rx_cfg: OVERSAMPLE must be even and >= 4");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("uart_rx_cfg: SYNC_STAGES must be >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rx_s;

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [SW-1:0]     samp_q, samp_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [1:0]        votes_q, votes_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              ferr_q, ferr_d;
  logic              perr_q, perr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              oferr_q, oferr_d;
  logic              operr_q, operr_d;
  logic              ovr_q, ovr_d;

  logic fall, tick, smp_dec, bit_end, vote, done;
  logic par_on, par_exp;

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      prev_q <= rx_s;
    end
  end

  // A start needs a 1->0 edge, so a held-low (break) line cannot re-trigger.
  assign fall    = prev_q & ~rx_s;
  assign tick    = (tick_q == T_END);
  assign smp_dec = tick && (samp_q == SMP_HI);
  assign bit_end = tick && (samp_q == SMP_END);
  assign vote    = (votes_q[1] & votes_q[0]) |
                   (votes_q[1] & rx_s) |
                   (votes_q[0] & rx_s);

`ifdef UART_RX_CFG_PARITY_EN
  logic [1:0] pm_q, pm_d;

  assign pm_d = (state_q == S_IDLE && fall) ? par_mode : pm_q;

  always_ff @(posedge clk) begin
    if (!rst_n) pm_q <= '0;
    else        pm_q <= pm_d;
  end

  assign par_on     = pm_q[0] ^ pm_q[1];
  assign par_exp    = (^shift_q) ^ pm_q[1];
  assign parity_err = operr_q;
`else
  logic unused_par;

  assign par_on     = 1'b0;
  assign par_exp    = 1'b0;
  assign parity_err = 1'b0;
  assign unused_par = ^{par_mode, operr_q};
`endif

  always_comb begin
    state_d = state_q;
    tick_d  = tick ? '0 : tick_q + 1'b1;
    samp_d  = samp_q;
    bit_d   = bit_q;
    votes_d = votes_q;
    shift_d = shift_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    done    = 1'b0;
    data_d  = data_q;
    valid_d = valid_q;
    oferr_d = oferr_q;
    operr_d = operr_q;
    ovr_d   = 1'b0;

    if (tick) samp_d = bit_end ? '0 : samp_q + 1'b1;
    if (tick && (samp_q == SMP_LO || samp_q == SMP_MID))
      votes_d = {votes_q[0], rx_s};

    unique case (state_q)
      S_IDLE: begin
        if (fall) begin
          state_d = S_START;
          tick_d  = '0;
          samp_d  = '0;
          bit_d   = '0;
          ferr_d  = 1'b0;
          perr_d  = 1'b0;
        end
      end
      S_START: begin
        if (smp_dec && vote) state_d = S_IDLE;
        else if (bit_end)    state_d = S_DATA;
      end
      S_DATA: begin
        if (smp_dec) shift_d = {vote, shift_q[DATA_W-1:1]};
        if (bit_end) begin
          if (bit_q == B_DLAST) begin
            bit_d   = '0;
            state_d = par_on ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (smp_dec) perr_d = vote ^ par_exp;
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (smp_dec) begin
          if (!vote) ferr_d = 1'b1;
          // Leave at the mid-sample so a back-to-back start edge is not missed.
          if (bit_q == B_SLAST) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end
        if (bit_end) bit_d = bit_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (done) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
        oferr_d = ferr_d;
        operr_d = perr_q;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      samp_q  <= '0;
      bit_q   <= '0;
      votes_q <= '0;
      shift_q <= '0;
      ferr_q  <= 1'b0;
      perr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      oferr_q <= 1'b0;
      operr_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      samp_q  <= samp_d;
      bit_q   <= bit_d;
      votes_q <= votes_d;
      shift_q <= shift_d;
      ferr_q  <= ferr_d;
      perr_q  <= perr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      oferr_q <= oferr_d;
      operr_q <= operr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign frame_err   = oferr_q;
  assign overrun_err = ovr_q;
  assign rx_idle     = (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed frames, expected words queued and popped on handshake.
// Parity cases follow UART_RX_CFG_PARITY_EN of the build.
module tb_uart_rx_cfg;

  localparam int BIT_CLK = 160;

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       p;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [1:0] par_mode;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_idle;
  logic       frame_err;
  logic       parity_err;
  logic       overrun_err;

  int total = 0;
  int bad   = 0;
  int words = 0;
  int vcyc  = 0;
  int ovr_cnt = 0;
  exp_t sb[$];

  uart_rx_cfg #(
    .FCLK(1600000),
    .FBAUD(10000),
    .OVERSAMPLE(16),
    .DATA_W(8),
    .STOP_BITS(1),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .par_mode(par_mode),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .rx_idle(rx_idle),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (overrun_err) ovr_cnt++;
      if (rx_valid) vcyc++;
      if (rx_valid && rx_ready) begin
        exp_t e;
        chk("sb_has_entry", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rx_data", rx_data, e.d);
          chk("frame_err", frame_err, e.f);
          chk("parity_err", parity_err, e.p);
        end
        words++;
      end
    end
  end

  task automatic clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    clks(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic use_par, input logic pbit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (use_par) send_bit(pbit);
    send_bit(stop);
    rx = 1'b1;
  endtask

  task automatic expect_word(input logic [7:0] d, input logic f,
                             input logic p);
    exp_t e;
    e.d = d;
    e.f = f;
    e.p = p;
    sb.push_back(e);
  endtask

  initial begin
    int v0;
    int w0;
    logic pb;
    rst_n    = 1'b0;
    rx       = 1'b1;
    rx_ready = 1'b1;
    par_mode = 2'b00;
    clks(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ovr", overrun_err, 0);
    chk("rst_idle", rx_idle, 1);
    rst_n = 1'b1;
    clks(20);

    // 1: clean 0xA5
    v0 = vcyc;
    expect_word(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    clks(20);
    chk("t1_valid_cycles", vcyc - v0, 1);
    chk("t1_idle", rx_idle, 1);
    chk("t1_sb_empty", sb.size(), 0);

    // 2: 60-clk glitch rejected
    w0 = words;
    rx = 1'b0;
    clks(60);
    rx = 1'b1;
    clks(200);
    chk("t2_no_word", words - w0, 0);
    chk("t2_idle", rx_idle, 1);
    expect_word(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
    clks(20);
    chk("t2_sb_empty", sb.size(), 0);

    // 3: bad stop bit then clean frame
    expect_word(8'h3C, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    clks(BIT_CLK);
    expect_word(8'h81, 1'b0, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0, 1'b0);
    clks(20);
    chk("t3_sb_empty", sb.size(), 0);

    // 4: overrun with consumer stalled
    rx_ready = 1'b0;
    v0 = ovr_cnt;
    expect_word(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    clks(20);
    chk("t4_ovr_cycles", ovr_cnt - v0, 1);
    chk("t4_valid_held", rx_valid, 1);
    chk("t4_data_held", rx_data, 8'h11);
    rx_ready = 1'b1;
    clks(1);
    chk("t4_valid_fall", rx_valid, 0);
    chk("t4_sb_empty", sb.size(), 0);
    clks(20);

    // 5: parity
    par_mode = 2'b01;
`ifdef UART_RX_CFG_PARITY_EN
    for (int k = 0; k < 3; k++) begin
      par_mode = (k == 2) ? 2'b10 : 2'b01;
      pb = (k == 1) ? 1'b1 : 1'b0;
      expect_word(8'h07, 1'b0, pb ^ (^8'h07) ^ par_mode[1]);
      send_frame(8'h07, 1'b1, 1'b1, pb);
      clks(20);
    end
`else
    pb = 1'b0;
    expect_word(8'h07, 1'b0, pb);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    clks(20);
`endif
    chk("t5_sb_empty", sb.size(), 0);
    par_mode = 2'b00;

    // 6: reset during data bit 4 of 0xF0
    w0 = words;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rx = 1'b1;
    clks(BIT_CLK / 2);
    chk("t6_busy", rx_idle, 0);
    rst_n = 1'b0;
    clks(1);
    rst_n = 1'b1;
    chk("t6_rst_valid", rx_valid, 0);
    chk("t6_rst_idle", rx_idle, 1);
    clks(BIT_CLK / 2 + 4 * BIT_CLK);
    chk("t6_no_word", words - w0, 0);
    expect_word(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    clks(20);
    chk("t6_sb_empty", sb.size(), 0);
    chk("ovr_total", ovr_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
